// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetches under a
// credit limit, tracks in-flight addresses, buffers returned words with their
// PCs and hands them to decode. A redirect flushes the buffer and marks the
// responses still in flight as stale so they are dropped on arrival.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [CW:0] DEPTH_OCC = DEPTH[CW:0];

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;
    logic [PW-1:0] fq_wr;
    logic [PW-1:0] fq_rd;
    logic [31:0]   aq_addr [DEPTH];
    logic [31:0]   fq_data [DEPTH];
    logic [31:0]   fq_pc   [DEPTH];
    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          push;
    logic          pop;

    // Fetch addresses are always word aligned, so the low redirect bits are dropped.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Every in-flight fetch holds a buffer slot in reserve, so the buffer can never overflow.
    assign occupancy      = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = rst_n && (occupancy < DEPTH_OCC) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored; stale or redirect-cycle responses are dropped.
    assign rsp_take = imem_rsp_valid && (inflight != '0);
    assign rsp_drop = rsp_take && (redirect_valid || (discard != '0));
    assign push     = rsp_take && !rsp_drop;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = fq_data[fq_rd];
    assign instr_pc    = fq_pc[fq_rd];

    // Program counter: a redirect wins, otherwise step one word per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    // Outstanding-request bookkeeping: in-flight count, stale count and address queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            discard  <= '0;
            aq_wr    <= '0;
            aq_rd    <= '0;
        end else begin
            case ({req_fire, rsp_take})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (redirect_valid) begin
                discard <= inflight - {{(CW-1){1'b0}}, rsp_take};
            end else if (rsp_take && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (req_fire) begin
                aq_wr <= aq_wr + 1'b1;
            end
            if (rsp_take) begin
                aq_rd <= aq_rd + 1'b1;
            end
        end
    end

    // Address queue storage: remember the PC of each issued fetch in issue order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                aq_addr[i] <= '0;
            end
        end else if (req_fire) begin
            aq_addr[aq_wr] <= pc;
        end
    end

    // Instruction buffer control: a redirect empties it, otherwise push/pop move the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq_wr <= '0;
            fq_rd <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            fq_wr <= '0;
            fq_rd <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fq_wr <= fq_wr + 1'b1;
            end
            if (pop) begin
                fq_rd <= fq_rd + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Instruction buffer storage: the word is paired with the oldest outstanding fetch address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fq_data[i] <= '0;
                fq_pc[i]   <= '0;
            end
        end else if (push) begin
            fq_data[fq_wr] <= imem_rsp_data;
            fq_pc[fq_wr]   <= aq_addr[aq_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a transaction-level model (queue of outstanding
// fetches tagged with a redirect epoch, queue of buffered instructions) is
// checked against the DUT every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    // Second instance only used to observe PC wrap-around from the top of memory.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          rdy;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    mreq_t       memq[$];
    ent_t        buffer[$];
    logic [31:0] fired_log[$];
    logic [31:0] cons_log[$];
    logic [31:0] mpc = RPC;
    int          epoch = 0;
    int          cyc = 0;
    int          lat_max = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        last_iv;
    logic        last_rv;
    logic [31:0] last_addr;
    logic [31:0] last_ipc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rdy, input bit rsp_en, input bit redir,
                        input logic [31:0] rpc, input bit irdy, input bit junk);
        bit    rsp_now;
        bit    exp_rv;
        bit    fire;
        mreq_t e;
        ent_t  b;
        @(negedge clk);
        cyc++;
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = irdy;
        rsp_now        = rsp_en && (memq.size() > 0) && (memq[0].rdy <= cyc);
        imem_rsp_valid = rsp_now || (junk && (memq.size() == 0));
        imem_rsp_data  = rsp_now ? memq[0].data : $urandom();
        #1;
        exp_rv = ((memq.size() + buffer.size()) < 2) && !redir;
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, mpc);
        chk("instr_valid", instr_valid, buffer.size() != 0);
        if (buffer.size() != 0) begin
            chk("instr", instr, buffer[0].data);
            chk("instr_pc", instr_pc, buffer[0].pc);
        end
        last_iv   = instr_valid;
        last_rv   = imem_req_valid;
        last_addr = imem_req_addr;
        last_ipc  = instr_pc;
        $display("cyc %0d req %b@%h rsp %b redir %b iv %b pc %h instr %h", cyc,
                 imem_req_valid, imem_req_addr, imem_rsp_valid, redir, instr_valid, instr_pc, instr);
        fire = exp_rv && rdy;
        if (redir) begin
            buffer.delete();
            epoch++;
            mpc = {rpc[31:2], 2'b00};
            if (rsp_now) begin
                e = memq.pop_front();
            end
        end else begin
            if ((buffer.size() != 0) && irdy) begin
                cons_log.push_back(buffer[0].pc);
                b = buffer.pop_front();
            end
            if (rsp_now) begin
                e = memq.pop_front();
                if (e.epoch == epoch) begin
                    b.pc   = e.addr;
                    b.data = e.data;
                    buffer.push_back(b);
                end
            end
            if (fire) begin
                e.addr  = mpc;
                e.data  = $urandom();
                e.rdy   = cyc + 1 + int'($urandom_range(0, lat_max));
                e.epoch = epoch;
                memq.push_back(e);
                fired_log.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Assert reset mid-cycle, check outputs immediately, hold with a bogus response, release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        memq.delete();
        buffer.delete();
        fired_log.delete();
        cons_log.delete();
        mpc = RPC;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom();
        @(negedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        // Streaming fetch with 1-cycle memory latency.
        do_reset();
        step(1, 1, 0, 0, 1, 0);
        chk("t1_iv_c0", last_iv, 0);
        @(posedge clk);
        #1;
        chk("wrap_addr", w_req_addr, 32'h0000_0000);
        step(1, 1, 0, 0, 1, 0);
        chk("t1_iv_c1", last_iv, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("t1_iv_c2", last_iv, 1);
        chk("t1_first_pc", last_ipc, 32'h0);
        repeat (9) step(1, 1, 0, 0, 1, 0);
        chk("t1_fire_n", fired_log.size() >= 3, 1);
        chk("t1_cons_n", cons_log.size() >= 3, 1);
        if (fired_log.size() >= 3 && cons_log.size() >= 3) begin
            chk("t1_fire0", fired_log[0], 32'h0);
            chk("t1_fire1", fired_log[1], 32'h4);
            chk("t1_fire2", fired_log[2], 32'h8);
            chk("t1_cons0", cons_log[0], 32'h0);
            chk("t1_cons1", cons_log[1], 32'h4);
            chk("t1_cons2", cons_log[2], 32'h8);
        end

        // Decode stalls: credits run out, head stays put, then fetch resumes at 8.
        do_reset();
        repeat (10) step(1, 1, 0, 0, 0, 0);
        chk("t2_req_valid", last_rv, 0);
        chk("t2_iv", last_iv, 1);
        chk("t2_head_pc", last_ipc, 32'h0);
        repeat (4) step(1, 1, 0, 0, 1, 0);
        chk("t2_fire_n", fired_log.size() >= 3, 1);
        if (fired_log.size() >= 3) chk("t2_resume", fired_log[2], 32'h8);

        // Redirect with two fetches outstanding; both stale responses dropped.
        do_reset();
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 32'h0000_0103, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("t3_iv_after", last_iv, 0);
        repeat (5) step(1, 1, 0, 0, 1, 0);
        chk("t3_fire_n", fired_log.size() >= 3, 1);
        chk("t3_cons_n", cons_log.size() >= 1, 1);
        if (fired_log.size() >= 3) chk("t3_new_addr", fired_log[2], 32'h100);
        if (cons_log.size() >= 1) chk("t3_first_pc", cons_log[0], 32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0200, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t4_iv", last_iv, 0);
        chk("t4_rv", last_rv, 1);
        chk("t4_addr", last_addr, 32'h200);

        // Randomised traffic with a mid-run asynchronous reset.
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                repeat (2) step(0, 0, 0, 0, 1, 1);
                chk("t6_iv", last_iv, 0);
                step(1, 0, 0, 0, 1, 0);
                chk("t6_restart_addr", last_addr, RPC);
                chk("t6_restart_rv", last_rv, 1);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom(),
                 $urandom_range(0, 3) != 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
